// File: rtl/gpr_sched_pkg.sv
// Shared encodings for the general-register write scheduler: target select,
// per-target write slot and swap sequencer states.
package gpr_sched_pkg;

    localparam logic TGT_A = 1'b0;
    localparam logic TGT_B = 1'b1;

    typedef enum logic {
        SLOT_EMPTY   = 1'b0,
        SLOT_PENDING = 1'b1
    } slot_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        XCHG  = 2'd2,
        DONE  = 2'd3
    } swap_state_t;

endpackage

// File: rtl/gpr_rr_arbiter.sv
// One-hot grant over NREQ requesters. With GPR_SCHED_RR_EN defined the search
// starts at a rotating pointer (winner+1 on advance); otherwise lowest index wins.
module gpr_rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

`ifdef GPR_SCHED_RR_EN
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) begin
            grant[win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        end
    end
`else
    logic found;
    logic unused_rr;

    // Fixed priority has no state, so clock, reset and advance go unused.
    assign unused_rr = ^{clk, rst, advance};

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/gpr_write_sched.sv
// Secondary write-port scheduler for general registers A and B: per-target slot,
// bus-collision deferral and atomic A<->B swap. Arbitration mode set by GPR_SCHED_RR_EN.
//
// state | meaning
// IDLE  | accepting requester writes; swap_req moves to DRAIN
// DRAIN | no new accepts; waiting for both slots to commit
// XCHG  | a_sec_in=b_val, b_sec_in=a_val, both sec_we; held while any bus_we
// DONE  | swap_done pulse, no writes
module gpr_write_sched
    import gpr_sched_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_tgt,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              a_bus_we,
    input  logic              b_bus_we,
    input  logic [W-1:0]      a_val,
    input  logic [W-1:0]      b_val,
    output logic              a_sec_we,
    output logic [W-1:0]      a_sec_in,
    output logic              b_sec_we,
    output logic [W-1:0]      b_sec_in,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              busy
);

    swap_state_t     state;
    slot_t           slot_a;
    slot_t           slot_b;
    logic [NREQ-1:0] req_a;
    logic [NREQ-1:0] req_b;
    logic [NREQ-1:0] grant_a;
    logic [NREQ-1:0] grant_b;
    logic            open_a;
    logic            open_b;
    logic            acc_a;
    logic            acc_b;
    logic [W-1:0]    data_a;
    logic [W-1:0]    data_b;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i] = req_valid[i] && (req_tgt[i] == TGT_A);
            req_b[i] = req_valid[i] && (req_tgt[i] == TGT_B);
        end
    end

    gpr_rr_arbiter #(.NREQ(NREQ)) u_arb_a (
        .clk     (clk),
        .rst     (rst),
        .req     (req_a),
        .advance (acc_a),
        .grant   (grant_a)
    );

    gpr_rr_arbiter #(.NREQ(NREQ)) u_arb_b (
        .clk     (clk),
        .rst     (rst),
        .req     (req_b),
        .advance (acc_b),
        .grant   (grant_b)
    );

    // A pending swap outranks every requester in the cycle it is raised.
    assign open_a    = (state == IDLE) && !swap_req && (slot_a == SLOT_EMPTY);
    assign open_b    = (state == IDLE) && !swap_req && (slot_b == SLOT_EMPTY);
    assign acc_a     = open_a && (|grant_a);
    assign acc_b     = open_b && (|grant_b);
    assign req_ready = ({NREQ{open_a}} & grant_a) | ({NREQ{open_b}} & grant_b);
    assign busy      = (slot_a == SLOT_PENDING) || (slot_b == SLOT_PENDING) || (state != IDLE);

    always_comb begin
        data_a = '0;
        data_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_a[i]) data_a = req_data[i*W +: W];
            if (grant_b[i]) data_b = req_data[i*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            slot_a    <= SLOT_EMPTY;
            slot_b    <= SLOT_EMPTY;
            a_sec_we  <= 1'b0;
            a_sec_in  <= '0;
            b_sec_we  <= 1'b0;
            b_sec_in  <= '0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (swap_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (slot_a == SLOT_EMPTY && slot_b == SLOT_EMPTY) begin
                        state    <= XCHG;
                        a_sec_we <= 1'b1;
                        b_sec_we <= 1'b1;
                        a_sec_in <= b_val;
                        b_sec_in <= a_val;
                    end
                end
                XCHG: begin
                    if (a_bus_we || b_bus_we) begin
                        a_sec_in <= b_val;
                        b_sec_in <= a_val;
                    end else begin
                        state     <= DONE;
                        a_sec_we  <= 1'b0;
                        b_sec_we  <= 1'b0;
                        swap_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Slots only fill in IDLE and XCHG needs both empty, so these never overlap the swap writes.
            if (slot_a == SLOT_PENDING) begin
                if (!a_bus_we) begin
                    slot_a   <= SLOT_EMPTY;
                    a_sec_we <= 1'b0;
                end
            end else if (acc_a) begin
                slot_a   <= SLOT_PENDING;
                a_sec_we <= 1'b1;
                a_sec_in <= data_a;
            end

            if (slot_b == SLOT_PENDING) begin
                if (!b_bus_we) begin
                    slot_b   <= SLOT_EMPTY;
                    b_sec_we <= 1'b0;
                end
            end else if (acc_b) begin
                slot_b   <= SLOT_PENDING;
                b_sec_we <= 1'b1;
                b_sec_in <= data_b;
            end
        end
    end

endmodule

// File: tb/tb_gpr_write_sched.sv
// Self-checking bench for gpr_write_sched: directed scenarios then random traffic,
// compared each cycle against a queue-based reference model of the scheduler.
module tb_gpr_write_sched;

    localparam int NREQ = 3;
    localparam int W    = 16;

    localparam int P_IDLE  = 0;
    localparam int P_DRAIN = 1;
    localparam int P_XCHG  = 2;
    localparam int P_DONE  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_tgt;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              a_bus_we;
    logic              b_bus_we;
    logic [W-1:0]      a_val;
    logic [W-1:0]      b_val;
    logic              a_sec_we;
    logic [W-1:0]      a_sec_in;
    logic              b_sec_we;
    logic [W-1:0]      b_sec_in;
    logic              swap_req;
    logic              swap_done;
    logic              busy;

    logic [W-1:0] reg_a = '0;
    logic [W-1:0] reg_b = '0;
    logic [W-1:0] a_bus_data;
    logic [W-1:0] b_bus_data;

    always #5 clk = ~clk;

    assign a_val = reg_a;
    assign b_val = reg_b;

    gpr_write_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_tgt   (req_tgt),
        .req_data  (req_data),
        .req_ready (req_ready),
        .a_bus_we  (a_bus_we),
        .b_bus_we  (b_bus_we),
        .a_val     (a_val),
        .b_val     (b_val),
        .a_sec_we  (a_sec_we),
        .a_sec_in  (a_sec_in),
        .b_sec_we  (b_sec_we),
        .b_sec_in  (b_sec_in),
        .swap_req  (swap_req),
        .swap_done (swap_done),
        .busy      (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: outstanding write per target, swap phase, RR pointers.
    logic [W-1:0] q_a[$];
    logic [W-1:0] q_b[$];
    int           ph;
    logic [W-1:0] xa;
    logic [W-1:0] xb;
    int           ptr[2];
    int           dut_log_a[$];
    int           done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        ph     = P_IDLE;
        ptr[0] = 0;
        ptr[1] = 0;
        xa     = '0;
        xb     = '0;
    endtask

    function automatic int pick(input int t);
        int best;
        int i;
        best = -1;
        for (int k = 0; k < NREQ; k++) begin
`ifdef GPR_SCHED_RR_EN
            i = (ptr[t] + k) % NREQ;
`else
            i = k;
`endif
            if (best < 0 && req_valid[i] && (req_tgt[i] == t[0])) best = i;
        end
        return best;
    endfunction

    task automatic clear_inputs();
        req_valid  = '0;
        req_tgt    = '0;
        req_data   = '0;
        a_bus_we   = 1'b0;
        b_bus_we   = 1'b0;
        a_bus_data = '0;
        b_bus_data = '0;
        swap_req   = 1'b0;
    endtask

    // One clock: check outputs at negedge, advance model and register environment after posedge.
    task automatic step();
        int              wa;
        int              wb;
        bit              can;
        bit              acc_a;
        bit              acc_b;
        bit              empty_a;
        bit              empty_b;
        logic [NREQ-1:0] exp_rdy;
        logic [W-1:0]    nra;
        logic [W-1:0]    nrb;
        @(negedge clk);
        empty_a = (q_a.size() == 0);
        empty_b = (q_b.size() == 0);
        can     = (ph == P_IDLE) && !swap_req;
        wa      = pick(0);
        wb      = pick(1);
        acc_a   = can && (wa >= 0) && empty_a;
        acc_b   = can && (wb >= 0) && empty_b;
        exp_rdy = '0;
        if (acc_a) exp_rdy[wa] = 1'b1;
        if (acc_b) exp_rdy[wb] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("a_sec_we", 32'(a_sec_we), 32'(!empty_a || ph == P_XCHG));
        chk("b_sec_we", 32'(b_sec_we), 32'(!empty_b || ph == P_XCHG));
        if (ph == P_XCHG) begin
            chk("a_sec_in_swap", 32'(a_sec_in), 32'(xa));
            chk("b_sec_in_swap", 32'(b_sec_in), 32'(xb));
        end else begin
            if (!empty_a) chk("a_sec_in", 32'(a_sec_in), 32'(q_a[0]));
            if (!empty_b) chk("b_sec_in", 32'(b_sec_in), 32'(q_b[0]));
        end
        chk("swap_done", 32'(swap_done), 32'(ph == P_DONE));
        chk("busy", 32'(busy), 32'(!empty_a || !empty_b || ph != P_IDLE));
        if (swap_done) done_seen++;
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && req_ready[i] && req_tgt[i] == 1'b0) dut_log_a.push_back(i);
        nra = a_bus_we ? a_bus_data : (a_sec_we ? a_sec_in : reg_a);
        nrb = b_bus_we ? b_bus_data : (b_sec_we ? b_sec_in : reg_b);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (!empty_a) begin
                if (!a_bus_we) q_a.delete(0);
            end else if (acc_a) begin
                q_a.push_back(req_data[wa*W +: W]);
                ptr[0] = (wa + 1) % NREQ;
            end
            if (!empty_b) begin
                if (!b_bus_we) q_b.delete(0);
            end else if (acc_b) begin
                q_b.push_back(req_data[wb*W +: W]);
                ptr[1] = (wb + 1) % NREQ;
            end
            case (ph)
                P_IDLE:  if (swap_req) ph = P_DRAIN;
                P_DRAIN: if (empty_a && empty_b) begin ph = P_XCHG; xa = reg_b; xb = reg_a; end
                P_XCHG:  if (a_bus_we || b_bus_we) begin xa = reg_b; xb = reg_a; end else ph = P_DONE;
                default: ph = P_IDLE;
            endcase
        end
        reg_a = nra;
        reg_b = nrb;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int d0;
        bit delayed;
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        model_reset();
        do_reset();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_we", 32'({a_sec_we, b_sec_we, swap_done}), 32'd0);

        // single write to A
        req_valid = 3'b001;
        req_data  = {16'h0000, 16'h0000, 16'h1234};
        step();
        clear_inputs();
        step();
        step();
        chk("t1_reg_a", 32'(reg_a), 32'h1234);

        // write to B deferred by three bus cycles
        do_reset();
        req_valid = 3'b010;
        req_tgt   = 3'b010;
        req_data  = {16'h0000, 16'hBEEF, 16'h0000};
        step();
        b_bus_we   = 1'b1;
        b_bus_data = 16'h5555;
        repeat (3) begin
            chk("t2_ready1_blocked", 32'(req_ready[1]), 32'd0);
            chk("t2_b_we_held", 32'(b_sec_we), 32'd1);
            step();
        end
        b_bus_we  = 1'b0;
        req_valid = '0;
        step();
        step();
        chk("t2_reg_b", 32'(reg_b), 32'hBEEF);

        // two requesters contending for A
        do_reset();
        dut_log_a.delete();
        repeat (8) begin
            req_valid = 3'b101;
            req_tgt   = 3'b000;
            req_data  = (NREQ*W)'({$urandom(), $urandom()});
            step();
        end
        clear_inputs();
        step();
        step();
        chk("t3_accepts", 32'(dut_log_a.size()), 32'd4);
        for (int k = 0; k < 4 && k < dut_log_a.size(); k++) begin
`ifdef GPR_SCHED_RR_EN
            chk("t3_grant_rr", 32'(dut_log_a[k]), (k % 2 == 0) ? 32'd0 : 32'd2);
`else
            chk("t3_grant_fixed", 32'(dut_log_a[k]), 32'd0);
`endif
        end

        // A and B accepted in the same cycle
        do_reset();
        req_valid = 3'b011;
        req_tgt   = 3'b010;
        req_data  = {16'h0000, 16'hBBBB, 16'hAAAA};
        step();
        clear_inputs();
        step();
        step();
        chk("t5_reg_a", 32'(reg_a), 32'hAAAA);
        chk("t5_reg_b", 32'(reg_b), 32'hBBBB);

        // swap with one bus collision during exchange
        do_reset();
        a_bus_we   = 1'b1;
        a_bus_data = 16'h0001;
        b_bus_we   = 1'b1;
        b_bus_data = 16'h0002;
        step();
        clear_inputs();
        swap_req = 1'b1;
        d0       = done_seen;
        delayed  = 1'b0;
        n        = 0;
        while (n < 20 && done_seen == d0) begin
            if (ph == P_XCHG && !delayed) begin
                a_bus_we   = 1'b1;
                a_bus_data = reg_a;
                delayed    = 1'b1;
            end else begin
                a_bus_we = 1'b0;
            end
            step();
            n++;
        end
        clear_inputs();
        chk("t4_latency", 32'(n), 32'd5);
        step();
        step();
        chk("t4_done_pulses", 32'(done_seen - d0), 32'd1);
        chk("t4_reg_a", 32'(reg_a), 32'h0002);
        chk("t4_reg_b", 32'(reg_b), 32'h0001);

        // reset with a pending slot, then reset mid-exchange
        do_reset();
        req_valid = 3'b001;
        req_data  = {16'h0000, 16'h0000, 16'h7777};
        step();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t6_a_we", 32'(a_sec_we), 32'd0);
        chk("t6_busy_slot", 32'(busy), 32'd0);
        swap_req = 1'b1;
        n        = 0;
        while (n < 10 && ph != P_XCHG) begin
            step();
            n++;
        end
        chk("t6_reached_xchg", 32'(ph == P_XCHG), 32'd1);
        d0       = done_seen;
        swap_req = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("t6_no_done", 32'(done_seen - d0), 32'd0);
        chk("t6_busy_swap", 32'(busy), 32'd0);
        chk("t6_we_cleared", 32'({a_sec_we, b_sec_we}), 32'd0);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            req_valid  = NREQ'($urandom());
            req_tgt    = NREQ'($urandom());
            req_data   = (NREQ*W)'({$urandom(), $urandom()});
            a_bus_we   = ($urandom_range(3) == 0);
            b_bus_we   = ($urandom_range(3) == 0);
            a_bus_data = W'($urandom());
            b_bus_data = W'($urandom());
            if (swap_req && (ph == P_DONE || $urandom_range(60) == 0)) swap_req = 1'b0;
            else if (!swap_req && $urandom_range(30) == 0) swap_req = 1'b1;
            rst = ($urandom_range(250) == 0);
            step();
        end
        rst = 1'b0;
        clear_inputs();
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
